// File: rtl/dds_multi_ctrl.sv
`default_nettype none
// ============================================================================
// dds_multi_ctrl : DDS phase accumulator with preset frequency-word stepping
//                  and an optional triangular sweep (macro DDS_MULTI_SWEEP_EN).
// Rev 1.0
// ============================================================================
module dds_multi_ctrl #(
   parameter int               ACC_W      = 32,
   parameter int               ADDR_W     = 12,
   parameter int               N_PRESET   = 5,
   parameter logic [ACC_W-1:0] FW0        = 8590,
   parameter logic [ACC_W-1:0] FW1        = 25770,
   parameter logic [ACC_W-1:0] FW2        = 85899,
   parameter logic [ACC_W-1:0] FW3        = 257698,
   parameter logic [ACC_W-1:0] FW4        = 858993,
   parameter logic [ACC_W-1:0] FW5        = 0,
   parameter logic [ACC_W-1:0] FW6        = 0,
   parameter logic [ACC_W-1:0] FW7        = 0,
   parameter logic [ACC_W-1:0] SWEEP_STEP = 4295,
   parameter int               SWEEP_DIV  = 50000
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              freq_flag,
   input  logic              mode_flag,
   input  logic              out_en,
   input  logic [ADDR_W-1:0] pword_in,
   output logic [ADDR_W-1:0] phase_addr,
   output logic [ACC_W-1:0]  fword,
   output logic [2:0]        preset_idx,
   output logic              mode,
   output logic              phase_wrap
);

   localparam logic [2:0] c_LAST_IDX = 3'(N_PRESET - 1);

   if (ADDR_W > ACC_W || N_PRESET < 1 || N_PRESET > 8 || SWEEP_DIV < 1 || SWEEP_STEP == '0) begin : g_bad_params
      $error("dds_multi_ctrl: illegal parameter set");
   end

   function automatic logic [ACC_W-1:0] f_fw(input logic [2:0] idx);
      case (idx)
         3'd0:    f_fw = FW0;
         3'd1:    f_fw = FW1;
         3'd2:    f_fw = FW2;
         3'd3:    f_fw = FW3;
         3'd4:    f_fw = FW4;
         3'd5:    f_fw = FW5;
         3'd6:    f_fw = FW6;
         default: f_fw = FW7;
      endcase
   endfunction

   logic [ACC_W-1:0]  r_acc;
   logic [ADDR_W-1:0] r_phase_addr;
   logic              r_wrap;
   logic [ACC_W-1:0]  r_fword;
   logic [2:0]        r_idx;
   logic [ACC_W:0]    w_acc_sum;
   logic [2:0]        w_next_idx;

   assign w_acc_sum  = {1'b0, r_acc} + {1'b0, r_fword};
   assign w_next_idx = (r_idx == c_LAST_IDX) ? 3'd0 : r_idx + 3'd1;

   // phase_addr follows the (held) accumulator every cycle, so a new pword_in
   // still reaches the ROM address while the accumulator is stopped.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc        <= '0;
         r_phase_addr <= '0;
         r_wrap       <= 1'b0;
      end else begin
         r_phase_addr <= r_acc[ACC_W-1 -: ADDR_W] + pword_in;
         if (out_en) begin
            r_acc  <= w_acc_sum[ACC_W-1:0];
            r_wrap <= w_acc_sum[ACC_W];
         end else begin
            r_wrap <= 1'b0;
         end
      end
   end

`ifdef DDS_MULTI_SWEEP_EN
   typedef enum logic [0:0] {S_FIXED = 1'b0, S_SWEEP = 1'b1} mode_t;

   localparam logic [ACC_W-1:0] c_FW_MAX   = f_fw(c_LAST_IDX);
   localparam int               c_DIV_W    = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SWEEP_DIV - 1);

   mode_t            r_mode;
   logic             r_dir_dn;
   logic [c_DIV_W-1:0] r_div;
   logic [ACC_W:0]   w_up_sum;
   logic [ACC_W:0]   w_dn_lim;
   logic             w_up_sat;
   logic             w_dn_sat;

   // Saturation is decided on ACC_W+1 bits so neither direction can wrap.
   assign w_up_sum = {1'b0, r_fword} + {1'b0, SWEEP_STEP};
   assign w_dn_lim = {1'b0, FW0} + {1'b0, SWEEP_STEP};
   assign w_up_sat = (w_up_sum >= {1'b0, c_FW_MAX});
   assign w_dn_sat = ({1'b0, r_fword} <= w_dn_lim);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode   <= S_FIXED;
         r_dir_dn <= 1'b0;
         r_div    <= '0;
         r_idx    <= '0;
         r_fword  <= FW0;
      end else if (mode_flag) begin
         if (r_mode == S_FIXED) begin
            r_mode   <= S_SWEEP;
            r_fword  <= FW0;
            r_dir_dn <= 1'b0;
            r_div    <= '0;
         end else begin
            r_mode  <= S_FIXED;
            r_fword <= f_fw(r_idx);
         end
      end else if (r_mode == S_FIXED) begin
         if (freq_flag) r_idx <= w_next_idx;
         r_fword <= f_fw(r_idx);
      end else if (r_div == c_DIV_LAST) begin
         r_div <= '0;
         if (!r_dir_dn) begin
            if (w_up_sat) begin
               r_fword  <= c_FW_MAX;
               r_dir_dn <= 1'b1;
            end else begin
               r_fword <= w_up_sum[ACC_W-1:0];
            end
         end else begin
            if (w_dn_sat) begin
               r_fword  <= FW0;
               r_dir_dn <= 1'b0;
            end else begin
               r_fword <= r_fword - SWEEP_STEP;
            end
         end
      end else begin
         r_div <= r_div + c_DIV_W'(1);
      end
   end

   assign mode = (r_mode == S_SWEEP);
`else
   logic w_unused_mode;

   assign w_unused_mode = mode_flag;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_fword <= FW0;
      end else begin
         if (freq_flag) r_idx <= w_next_idx;
         r_fword <= f_fw(r_idx);
      end
   end

   assign mode = 1'b0;
`endif

   assign phase_addr = r_phase_addr;
   assign phase_wrap = r_wrap;
   assign fword      = r_fword;
   assign preset_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_dds_multi_ctrl.sv
`default_nettype none
// Directed bench for dds_multi_ctrl with a scoreboard queue of expected values.
`timescale 1ns/1ps
module tb_dds_multi_ctrl;

   localparam int          ACC_W  = 32;
   localparam int          ADDR_W = 12;
   localparam longint      STEP   = 4295;
   localparam logic [31:0] FWT [0:4] = '{32'd8590, 32'd25770, 32'd85899, 32'd257698, 32'd858993};

   logic              sys_clk;
   logic              rst_n;
   logic              freq_flag;
   logic              mode_flag;
   logic              out_en;
   logic [ADDR_W-1:0] pword_in;
   logic [ADDR_W-1:0] phase_addr;
   logic [ACC_W-1:0]  fword;
   logic [2:0]        preset_idx;
   logic              mode;
   logic              phase_wrap;

   dds_multi_ctrl #(
      .ACC_W     (ACC_W),
      .ADDR_W    (ADDR_W),
      .N_PRESET  (5),
      .SWEEP_STEP(32'd4295),
      .SWEEP_DIV (4)
   ) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .freq_flag (freq_flag),
      .mode_flag (mode_flag),
      .out_en    (out_en),
      .pword_in  (pword_in),
      .phase_addr(phase_addr),
      .fword     (fword),
      .preset_idx(preset_idx),
      .mode      (mode),
      .phase_wrap(phase_wrap)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic expect_val(input string tag, input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check_next(input logic [63:0] obs);
      exp_t e;
      n_checks++;
      assert (sb.size() != 0) else begin
         n_errors++;
         $error("FAIL scoreboard_empty: observed %0d expected an entry", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.val) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   logic [31:0] m_acc;
   logic [32:0] m_sum;
   logic [11:0] m_addr;
   int          first_wrap;
   int          n_wrap;
   longint      cur, nxt, peak, low_after_peak;
   bit          dn;
   bit          peaked;

   initial begin
      rst_n = 1'b0; freq_flag = 1'b0; mode_flag = 1'b0; out_en = 1'b0; pword_in = '0;
      #12;
      expect_val("rst_phase_addr", 64'd0);  check_next(64'(phase_addr));
      expect_val("rst_fword", 64'd8590);    check_next(64'(fword));
      expect_val("rst_preset_idx", 64'd0);  check_next(64'(preset_idx));
      expect_val("rst_mode", 64'd0);        check_next(64'(mode));
      expect_val("rst_phase_wrap", 64'd0);  check_next(64'(phase_wrap));

      @(posedge sys_clk); #1;
      rst_n = 1'b1;
      tick(); tick();

      // Preset stepping: pulses 4 cycles apart, fword lags preset_idx by one.
      for (int i = 1; i <= 5; i++) begin
         freq_flag = 1'b1;
         expect_val("preset_idx", 64'(i % 5));
         expect_val("preset_fword", 64'(FWT[i % 5]));
         tick();
         freq_flag = 1'b0;
         tick();
         check_next(64'(preset_idx));
         check_next(64'(fword));
         tick(); tick();
      end

      pword_in = 12'd1024;
      for (int i = 0; i < 3; i++) begin
         expect_val("offset_phase_addr", 64'd1024);
         expect_val("offset_phase_wrap", 64'd0);
         tick();
         check_next(64'(phase_addr));
         check_next(64'(phase_wrap));
      end

      for (int i = 0; i < 4; i++) begin
         freq_flag = 1'b1; tick();
         freq_flag = 1'b0; tick();
      end
      tick();
      expect_val("preset4_fword", 64'(FWT[4]));
      check_next(64'(fword));

      // Accumulate from acc = 0 with a phase offset, cycle-by-cycle model.
      m_acc = '0; first_wrap = -1; n_wrap = 0;
      pword_in = 12'd100;
      out_en = 1'b1;
      for (int t = 1; t <= 15100; t++) begin
         m_sum  = {1'b0, m_acc} + {1'b0, FWT[4]};
         m_addr = m_acc[31:20] + 12'd100;
         expect_val("run_phase_addr", 64'(m_addr));
         expect_val("run_phase_wrap", 64'(m_sum[32]));
         m_acc = m_sum[31:0];
         tick();
         check_next(64'(phase_addr));
         check_next(64'(phase_wrap));
         if (phase_wrap === 1'b1) begin
            n_wrap++;
            if (first_wrap < 0) first_wrap = t;
         end
      end
      expect_val("first_wrap_in_window", 64'd1);
      check_next(64'((first_wrap >= 4999) && (first_wrap <= 5001)));
      expect_val("wrap_count", 64'd3);
      check_next(64'(n_wrap));

      out_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_addr = m_acc[31:20] + 12'd100;
         expect_val("hold_phase_addr", 64'(m_addr));
         expect_val("hold_phase_wrap", 64'd0);
         tick();
         check_next(64'(phase_addr));
         check_next(64'(phase_wrap));
      end

      // Simultaneous mode_flag and freq_flag.
      mode_flag = 1'b1; freq_flag = 1'b1;
      tick();
      mode_flag = 1'b0; freq_flag = 1'b0;
`ifdef DDS_MULTI_SWEEP_EN
      expect_val("prio_mode", 64'd1);
      expect_val("prio_preset_idx", 64'd4);
      expect_val("prio_fword", 64'(FWT[0]));
`else
      expect_val("prio_mode", 64'd0);
      expect_val("prio_preset_idx", 64'd0);
      expect_val("prio_fword", 64'(FWT[4]));
`endif
      check_next(64'(mode));
      check_next(64'(preset_idx));
      check_next(64'(fword));

`ifdef DDS_MULTI_SWEEP_EN
      // Triangular trajectory: one value per 4 cycles, saturating at both ends.
      cur = longint'(FWT[0]); dn = 1'b0;
      for (int u = 0; u < 410; u++) begin
         for (int k = 0; k < 4; k++)
            if (4 * u + k >= 1) expect_val("sweep_fword", 64'(cur));
         if (!dn) begin
            nxt = (cur + STEP < longint'(FWT[4])) ? cur + STEP : longint'(FWT[4]);
            if (nxt == longint'(FWT[4])) dn = 1'b1;
         end else begin
            nxt = (cur - STEP > longint'(FWT[0])) ? cur - STEP : longint'(FWT[0]);
            if (nxt == longint'(FWT[0])) dn = 1'b0;
         end
         cur = nxt;
      end
      peak = 0; low_after_peak = 64'h7fff_ffff; peaked = 1'b0;
      for (int t = 1; t <= 1639; t++) begin
         if (t == 20) freq_flag = 1'b1;
         if (t == 21) freq_flag = 1'b0;
         tick();
         check_next(64'(fword));
         if (longint'(fword) > peak) peak = longint'(fword);
         if (longint'(fword) == longint'(FWT[4])) peaked = 1'b1;
         if (peaked && longint'(fword) < low_after_peak) low_after_peak = longint'(fword);
      end
      expect_val("sweep_peak", 64'(FWT[4]));
      check_next(64'(peak));
      expect_val("sweep_floor", 64'(FWT[0]));
      check_next(64'(low_after_peak));
      expect_val("sweep_mode", 64'd1);
      check_next(64'(mode));
      expect_val("sweep_preset_idx", 64'd4);
      check_next(64'(preset_idx));
`else
      freq_flag = 1'b1; tick();
      freq_flag = 1'b0; tick();
`endif

      // Reset in the middle of accumulation (and of the sweep when built in).
      pword_in = 12'd300;
      out_en = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      expect_val("midrst_phase_addr", 64'd0);  check_next(64'(phase_addr));
      expect_val("midrst_fword", 64'd8590);    check_next(64'(fword));
      expect_val("midrst_preset_idx", 64'd0);  check_next(64'(preset_idx));
      expect_val("midrst_mode", 64'd0);        check_next(64'(mode));
      expect_val("midrst_phase_wrap", 64'd0);  check_next(64'(phase_wrap));

      @(posedge sys_clk); #1;
      rst_n = 1'b1;
      for (int n = 1; n <= 124; n++) begin
         tick();
         if (n == 1) begin
            expect_val("post_rst_phase_addr", 64'd300);
            expect_val("post_rst_fword", 64'd8590);
            check_next(64'(phase_addr));
            check_next(64'(fword));
         end
         if (n == 123) begin
            expect_val("first_acc_addr_n123", 64'd300);
            check_next(64'(phase_addr));
         end
         if (n == 124) begin
            expect_val("first_acc_addr_n124", 64'd301);
            check_next(64'(phase_addr));
         end
      end

      assert (sb.size() == 0) else begin
         n_errors++;
         $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
